fifo_rd_ctrl: RTL
=================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, the data word width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fifo_empty  input  1  FIFO empty flag; no word available when high.
REQ-005 SHALL have port fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-006 SHALL have port fifo_underflow  input  1  FIFO underflow indication.
REQ-007 SHALL have port fifo_rd_en  output  1  read request to the FIFO.
REQ-008 SHALL have port m_data  output  FIFO_WIDTH  downstream data, head of the output buffer.
REQ-009 SHALL have port m_valid  output  1  downstream data valid.
REQ-010 SHALL have port m_ready  input  1  downstream ready; a transfer occurs when m_valid and m_ready are both high.
REQ-011 SHALL have port rd_count  output  16  count of words delivered downstream; wraps modulo 2^16.
REQ-012 SHALL have port err_underflow  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL treat the FIFO as 1-cycle read latency: rd_en high in cycle N -> fifo_data_out is valid in cycle N+1.
REQ-014 SHALL keep an inflight flag, registered from fifo_rd_en each cycle.
REQ-015 SHALL contain a 2-entry FIFO-ordered output buffer with occupancy cnt in 0..2.
REQ-016 SHALL capture fifo_data_out into the buffer tail at the end of any cycle in which inflight is high.
REQ-017 SHALL drive fifo_rd_en = !fifo_empty && (cnt + inflight - pop) < 2, where pop = m_valid && m_ready. This is combinational and allows back-to-back reads.
REQ-018 SHALL never assert fifo_rd_en while fifo_empty is high.
REQ-019 SHALL drive m_valid = (cnt != 0) and m_data = buffer head, both driven from registered state.
REQ-020 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-021 SHALL, when capture and pop occur in the same cycle, pop the head and append the captured word; cnt is unchanged.
REQ-022 SHALL never overflow the buffer: cnt + inflight <= 2 at all times.
REQ-023 SHALL never drop, duplicate or reorder words.
REQ-024 SHALL give a first-word latency of 2 cycles: fifo_empty falls in cycle N -> rd_en in N -> capture at end of N+1 -> m_valid high in N+2.
REQ-025 SHALL sustain 1 word/cycle in steady state while the FIFO is non-empty and m_ready stays high.
REQ-026 SHALL increment rd_count by 1 on every pop, wrapping from 0xFFFF to 0x0000.
REQ-027 SHALL set err_underflow when fifo_underflow is high on a clock edge; it stays set until reset.

Reset
REQ-028 SHALL, when rst_n is low, immediately clear cnt, inflight, rd_count and err_underflow, and force m_valid=0.
REQ-029 SHALL hold fifo_rd_en=0 while rst_n is low.
REQ-030 SHALL clear buffer data registers to 0 on reset, giving m_data=0.
REQ-031 SHALL discard any in-flight read or buffered words on reset mid-operation; no stale word appears after reset release.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-033 SHALL cover single word: FIFO holds 0xA5A5, m_ready=1 -> rd_en one cycle, m_valid for exactly one cycle 2 cycles later, m_data=0xA5A5, rd_count=1.
REQ-034 SHALL cover streaming: 8 words 0x0001..0x0008, m_ready=1 -> 8 consecutive m_valid cycles in order, rd_count=8.
REQ-035 SHALL cover backpressure: m_ready=0 with FIFO non-empty -> exactly 2 reads issued, then rd_en=0, m_data held. On m_ready=1, order is preserved and there is no bubble beyond the pipeline.
REQ-036 SHALL cover empty boundary: FIFO drains to empty mid-stream -> rd_en deasserts the same cycle and the remaining buffered words are still delivered.
REQ-037 SHALL cover reset mid-stream: rst_n low with cnt=2 and inflight=1 -> m_valid=0 immediately, rd_count=0, and no old word appears after release.
REQ-038 SHALL cover wrap and error: preload rd_count=0xFFFF and pop once -> 0x0000. A one-cycle fifo_underflow pulse -> err_underflow=1 held until reset.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a 1-cycle-latency FIFO: prefetches words into a
// 2-entry skid buffer and presents them on a valid/ready downstream port.
module fifo_rd_ctrl #(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [15:0]           rd_count,
    output logic                  err_underflow
);

    logic [1:0]            cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
    logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic                  err_q, err_d;
    logic                  pop;
    logic                  capture;
    logic [2:0]            occupancy_next;

    // A read is only issued if the word it returns is guaranteed a buffer slot.
    always_comb begin
        pop            = (cnt_q != 2'd0) && m_ready;
        capture        = inflight_q;
        occupancy_next = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en     = rst_n && !fifo_empty && (occupancy_next < 3'd2);
        inflight_d     = fifo_rd_en;

        cnt_d  = cnt_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({capture, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf1_d = fifo_data_out;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data_out;
                end
            end
            default: ;
        endcase

        rd_count_d = rd_count_q + {15'd0, pop};
        err_d      = err_q | fifo_underflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            rd_count_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            rd_count_q <= rd_count_d;
            err_q      <= err_d;
        end
    end

    assign m_valid       = (cnt_q != 2'd0);
    assign m_data        = buf0_q;
    assign rd_count      = rd_count_q;
    assign err_underflow = err_q;

endmodule
